counter_scheduler: RTL and testbench

- Shares one Generic_counter instance between NUM_REQ requesters, each asking for a timed run of a given length.
- Arbitrates among the requesters, then loads the counter with zero and enables it until it reaches the requested terminal value.
- Reports completion to the winning requester with a one-cycle done pulse.
- Sits directly in front of the counter: drives its load, enable and cnt_in, and observes cnt_out.

---
 rtl/cnt_sched_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/counter_scheduler.sv | 108 ++++++++++
 tb/tb_counter_scheduler.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_sched_pkg.sv
// Shared state encoding and the req_len slice helper for counter_scheduler.
package cnt_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int MaxReqLenBits = 512;
  localparam int MaxSliceBits  = 32;

  // Bit-serial slice pick keeps the helper usable for any NUM_REQ/WIDTH combination.
  function automatic logic [MaxSliceBits-1:0] getSlice(input logic [MaxReqLenBits-1:0] vec,
                                                       input int width,
                                                       input int idx);
    logic [MaxSliceBits-1:0] slice;
    logic [8:0] pos;
    slice = '0;
    for (int b = 0; b < MaxSliceBits; b++) begin
      if (b < width) begin
        pos = 9'(idx * width + b);
        slice[b] = vec[pos];
      end
    end
    return slice;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational requester arbiter; round-robin from ptr_i by default,
// lowest-index fixed priority when CNT_SCHED_FIXED_PRIO_EN is defined.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
`ifndef CNT_SCHED_FIXED_PRIO_EN
  input  logic [IDW-1:0]     ptr_i,
`endif
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     idx_o,
  output logic               any_req_o
);

  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    idx_o     = '0;
    cand      = '0;
    found     = 1'b0;
    any_req_o = |req_i;
`ifdef CNT_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDW'(i);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((int'(ptr_i) + k) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
`endif
    gnt_o = any_req_o ? (NUM_REQ'(1) << idx_o) : '0;
  end

endmodule

// File: rtl/counter_scheduler.sv
// Time-shares one external counter among NUM_REQ requesters (IDLE/LOAD/RUN/DONE).
// Define CNT_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module counter_scheduler
  import cnt_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 5,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_len,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     cnt_load,
  output logic                     cnt_enable,
  output logic [WIDTH-1:0]         cnt_din,
  input  logic [WIDTH-1:0]         cnt_q
);

  state_e               state_q;
  logic [IDW-1:0]       id_q;
  logic [WIDTH-1:0]     len_q;
  logic [WIDTH-1:0]     len_d;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [NUM_REQ-1:0]   winGnt;
  logic [IDW-1:0]       winIdx;
  logic                 anyReq;

`ifndef CNT_SCHED_FIXED_PRIO_EN
  logic [IDW-1:0]       ptr_q;
  logic [IDW-1:0]       nextPtr;
  assign nextPtr = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_arb (
    .req_i     (req),
`ifndef CNT_SCHED_FIXED_PRIO_EN
    .ptr_i     (ptr_q),
`endif
    .gnt_o     (winGnt),
    .idx_o     (winIdx),
    .any_req_o (anyReq)
  );

  assign len_d = WIDTH'(getSlice(MaxReqLenBits'(req_len), WIDTH, int'(winIdx)));

  // Abort has priority over completion when req drops on the terminal cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      len_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
`ifndef CNT_SCHED_FIXED_PRIO_EN
      ptr_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            id_q    <= winIdx;
            len_q   <= len_d;
            gnt_q   <= winGnt;
            state_q <= LOAD;
          end
        end
        LOAD: state_q <= RUN;
        RUN: begin
          if (!req[id_q]) begin
            gnt_q   <= '0;
            state_q <= IDLE;
`ifndef CNT_SCHED_FIXED_PRIO_EN
            ptr_q   <= nextPtr;
`endif
          end else if (cnt_q == len_q) begin
            done_q  <= gnt_q;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= '0;
          gnt_q   <= '0;
          state_q <= IDLE;
`ifndef CNT_SCHED_FIXED_PRIO_EN
          ptr_q   <= nextPtr;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);
  assign cnt_load   = (state_q == LOAD);
  assign cnt_enable = (state_q == RUN) && (cnt_q != len_q);
  assign cnt_din    = '0;

endmodule

// File: tb/tb_counter_scheduler.sv
// Self-checking bench for counter_scheduler with a behavioural counter attached.
// Honours CNT_SCHED_FIXED_PRIO_EN when computing expected grant order.
module tb_counter_scheduler;

  localparam int N = 4;
  localparam int W = 5;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] reqLen = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;
  logic           cntLoad;
  logic           cntEnable;
  logic [W-1:0]   cntDin;
  logic [W-1:0]   cntQ;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [N-1:0]   reqMask;
    logic [N*W-1:0] lens;
    int             expId;
    int             expLen;
  } vec_t;

  vec_t tbl[9];

  always #5 clk = ~clk;

  // Stand-in for the shared counter: load wins over enable, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cntQ <= '0;
    else if (cntLoad) cntQ <= cntDin;
    else if (cntEnable) cntQ <= cntQ + 1'b1;
  end

  counter_scheduler #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_len    (reqLen),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .cnt_load   (cntLoad),
    .cnt_enable (cntEnable),
    .cnt_din    (cntDin),
    .cnt_q      (cntQ)
  );

  // Expected outputs rel cycles after the accepting IDLE cycle (rel 0).
  function automatic logic [15:0] expRun(input int id, input int len, input int rel);
    logic [N-1:0] oh;
    logic [N-1:0] g;
    logic [N-1:0] d;
    logic b, l, e;
    oh = 4'b0001 << id;
    b  = (rel >= 1) && (rel <= len + 3);
    g  = b ? oh : '0;
    d  = (rel == len + 3) ? oh : '0;
    l  = (rel == 1);
    e  = (rel >= 2) && (rel <= len + 1);
    return {g, d, b, l, e, 5'b0};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] expVal);
    logic [15:0] act;
    act = {gnt, done, busy, cntLoad, cntEnable, cntDin};
    vectors++;
    if (act !== expVal) begin
      miscompares++;
      $display("[TB] FAIL %s: got gnt/done/busy/load/en/din=%h expected %h at %0t",
               name, act, expVal, $time);
    end
  endtask

  task automatic checkCount(input string name, input int actVal, input int expVal);
    vectors++;
    if (actVal != expVal) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actVal, expVal, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b0;
    req = '0;
    reqLen = '0;
    @(negedge clk);
    checkOutput("reset_state", 16'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    nextCycle();
  endtask

  // Presents one request pattern in an IDLE cycle and checks every cycle of the run.
  task automatic applyStimulus(input logic [N-1:0] r, input logic [N*W-1:0] lens,
                               input int expId, input int expLen, input bit dropAfter,
                               input string name);
    req = r;
    reqLen = lens;
    for (int rel = 0; rel <= expLen + 3; rel++) begin
      if (rel > 0) nextCycle();
      if (rel == 1) reqLen = ~lens;
      @(negedge clk);
      checkOutput(name, expRun(expId, expLen, rel));
      if (rel == expLen + 3) begin
        checkCount({name, "_cnt_at_done"}, int'(cntQ), expLen);
        if (dropAfter) req = '0;
      end
    end
    nextCycle();
  endtask

  task automatic waitForCount(input int target, input string name, output int sawDone);
    int hit;
    hit = 0;
    sawDone = 0;
    for (int c = 0; c < 40 && hit == 0; c++) begin
      nextCycle();
      @(negedge clk);
      if (done != '0) sawDone = 1;
      if (int'(cntQ) == target) hit = 1;
    end
    checkCount({name, "_reached"}, hit, 1);
  endtask

  initial begin
    int sawDone;
    int mBusy, mAcc, mId, mLen, mPtr, rel, win, doneNow, idleNow;
    logic [15:0] e;

    tbl[0] = '{4'b0001, {5'd0, 5'd0, 5'd0, 5'd3},   0, 3};
    tbl[1] = '{4'b0100, {5'd7, 5'd0, 5'd9, 5'd4},   2, 0};
    tbl[2] = '{4'b0010, {5'd2, 5'd3, 5'd31, 5'd6},  1, 31};
`ifdef CNT_SCHED_FIXED_PRIO_EN
    tbl[3] = '{4'b1111, {5'd1, 5'd1, 5'd1, 5'd1},   0, 1};
    tbl[4] = '{4'b1111, {5'd1, 5'd1, 5'd1, 5'd1},   0, 1};
    tbl[5] = '{4'b1111, {5'd1, 5'd1, 5'd1, 5'd1},   0, 1};
    tbl[6] = '{4'b1111, {5'd1, 5'd1, 5'd1, 5'd1},   0, 1};
    tbl[7] = '{4'b1001, {5'd4, 5'd9, 5'd9, 5'd2},   0, 2};
    tbl[8] = '{4'b1001, {5'd4, 5'd9, 5'd9, 5'd2},   0, 2};
`else
    tbl[3] = '{4'b1111, {5'd1, 5'd1, 5'd1, 5'd1},   2, 1};
    tbl[4] = '{4'b1111, {5'd1, 5'd1, 5'd1, 5'd1},   3, 1};
    tbl[5] = '{4'b1111, {5'd1, 5'd1, 5'd1, 5'd1},   0, 1};
    tbl[6] = '{4'b1111, {5'd1, 5'd1, 5'd1, 5'd1},   1, 1};
    tbl[7] = '{4'b1001, {5'd4, 5'd9, 5'd9, 5'd2},   3, 4};
    tbl[8] = '{4'b1001, {5'd4, 5'd9, 5'd9, 5'd2},   0, 2};
`endif

    resetDut();

    // All requesters held high: grant order 0,1,2,3,0 (always 0 under fixed priority).
    for (int k = 0; k < 5; k++) begin
`ifdef CNT_SCHED_FIXED_PRIO_EN
      applyStimulus(4'b1111, {5'd1, 5'd1, 5'd1, 5'd1}, 0, 1, 1'b0, "rr_order");
`else
      applyStimulus(4'b1111, {5'd1, 5'd1, 5'd1, 5'd1}, k % N, 1, 1'b0, "rr_order");
`endif
    end

    resetDut();
    for (int i = 0; i < 9; i++) begin
      applyStimulus(tbl[i].reqMask, tbl[i].lens, tbl[i].expId, tbl[i].expLen, 1'b1,
                    $sformatf("table_%0d", i));
    end

    // Abort: requester 1 drops at cnt_q == 4, pending requester 3 goes next.
    resetDut();
    req = 4'b1010;
    reqLen = {5'd2, 5'd0, 5'd10, 5'd0};
    @(negedge clk);
    checkOutput("abort_accept", 16'h0);
    waitForCount(4, "abort", sawDone);
    checkCount("abort_no_done_before", sawDone, 0);
    req = 4'b1000;
    nextCycle();
    @(negedge clk);
    checkOutput("abort_idle", 16'h0);
    for (int rel = 1; rel <= 5; rel++) begin
      nextCycle();
      @(negedge clk);
      checkOutput("abort_next_grant", expRun(3, 2, rel));
      if (rel == 5) req = '0;
    end
    nextCycle();

    // Mid-run reset with a non-zero pointer; afterwards requester 0 must win first.
    applyStimulus(4'b0010, {5'd0, 5'd0, 5'd1, 5'd0}, 1, 1, 1'b1, "pre_reset");
    req = 4'b0100;
    reqLen = {5'd0, 5'd10, 5'd0, 5'd0};
    waitForCount(5, "reset_run", sawDone);
    rst = 1'b0;
    #1;
    checkOutput("reset_async", 16'h0);
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    nextCycle();
    applyStimulus(4'b1111, {5'd1, 5'd1, 5'd1, 5'd1}, 0, 1, 1'b1, "post_reset_ptr");

    // Randomized traffic against a schedule-based reference model.
    resetDut();
    mBusy = 0; mAcc = 0; mId = 0; mLen = 0; mPtr = 0;
    for (int t = 0; t < 3000; t++) begin
      doneNow = 0;
      idleNow = (mBusy == 0);
      e = 16'h0;
      if (mBusy != 0) begin
        rel = t - mAcc;
        e = expRun(mId, mLen, rel);
        if (rel == mLen + 3) begin
          doneNow = 1;
          req[mId] = 1'b0;
          mBusy = 0;
          mPtr = (mId + 1) % N;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!req[i] && !(doneNow != 0 && i == mId) && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        reqLen[i*W +: W] = ($urandom_range(0, 15) == 0) ? 5'd31 : W'($urandom_range(0, 6));
      end
      if (idleNow != 0 && req != '0) begin
        win = -1;
        for (int k = 0; k < N; k++) begin
`ifdef CNT_SCHED_FIXED_PRIO_EN
          if (win < 0 && req[k]) win = k;
`else
          if (win < 0 && req[(mPtr + k) % N]) win = (mPtr + k) % N;
`endif
        end
        mId = win;
        mAcc = t;
        mLen = int'(reqLen[win*W +: W]);
        mBusy = 1;
      end
      @(negedge clk);
      checkOutput("random", e);
      nextCycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
